// File: rtl/usb_pkg.sv
// Shared USB definitions for the receive and transmit paths.
// Holds PID bytes, packet-type codes, line states, FSM states and CRC16 constants.
package usb_pkg;

   localparam logic [7:0] PID_OUT   = 8'hE1;
   localparam logic [7:0] PID_IN    = 8'h69;
   localparam logic [7:0] PID_DATA0 = 8'hC3;
   localparam logic [7:0] PID_DATA1 = 8'h4B;
   localparam logic [7:0] PID_ACK   = 8'hD2;
   localparam logic [7:0] PID_NAK   = 8'h5A;
   localparam logic [7:0] PID_STALL = 8'h1E;

   localparam logic [2:0] PKT_NONE  = 3'd0;
   localparam logic [2:0] PKT_OUT   = 3'd1;
   localparam logic [2:0] PKT_IN    = 3'd2;
   localparam logic [2:0] PKT_DATA0 = 3'd3;
   localparam logic [2:0] PKT_DATA1 = 3'd4;
   localparam logic [2:0] PKT_ACK   = 3'd5;
   localparam logic [2:0] PKT_NAK   = 3'd6;
   localparam logic [2:0] PKT_STALL = 3'd7;

   // SYNC decodes to 0000_0001 in wire order, i.e. 0x80 once shifted in LSB first
   localparam logic [7:0]  SYNC_PATTERN   = 8'h80;
   localparam logic [15:0] CRC16_POLY     = 16'h8005;
   localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
   localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

   typedef enum logic [1:0] {
      LINE_SE0 = 2'b00,
      LINE_K   = 2'b01,
      LINE_J   = 2'b10,
      LINE_SE1 = 2'b11
   } line_t;

   typedef enum logic [2:0] {
      RX_IDLE, RX_SYNC, RX_PID, RX_TOKEN, RX_DATA, RX_EOP, RX_ERR
   } rx_state_t;

   function automatic logic [2:0] pidToPacket(input logic [7:0] pid);
      case (pid)
         PID_OUT:   return PKT_OUT;
         PID_IN:    return PKT_IN;
         PID_DATA0: return PKT_DATA0;
         PID_DATA1: return PKT_DATA1;
         PID_ACK:   return PKT_ACK;
         PID_NAK:   return PKT_NAK;
         PID_STALL: return PKT_STALL;
         default:   return PKT_NONE;
      endcase
   endfunction

endpackage

// File: rtl/usb_crc16.sv
// Serial USB CRC16 engine, one bit per enabled cycle in wire order.
// Shared between the receive and transmit paths.
module usb_crc16 import usb_pkg::*; (
   input  logic        clk,
   input  logic        rst,
   input  logic        clear_i,
   input  logic        shift_en_i,
   input  logic        bit_in_i,
   output logic [15:0] crc_o
);

   logic [15:0] crc_q;
   logic        feedback;

   assign feedback = bit_in_i ^ crc_q[15];

   always_ff @(posedge clk) begin
      if (rst || clear_i) begin
         crc_q <= CRC16_INIT;
      end else if (shift_en_i) begin
         crc_q <= {crc_q[14:0], 1'b0} ^ (feedback ? CRC16_POLY : 16'h0000);
      end
   end

   assign crc_o = crc_q;

endmodule

// File: rtl/usb_rx.sv
// USB full-speed receive path: synchronizer, bit timing, NRZI decode, unstuffing,
// packet FSM with PID/CRC16 checks and a 2-byte hold pipe that keeps CRC bytes out of the buffer.
module usb_rx import usb_pkg::*; #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       Dplus_In,
   input  logic       Dminus_In,
   input  logic [6:0] Buffer_Occupancy,
   output logic [2:0] RX_Packet,
   output logic       RX_Data_Ready,
   output logic       RX_Transfer_Active,
   output logic       RX_Error,
   output logic       Flush,
   output logic       Store_RX_Packet_Data,
   output logic [7:0] RX_Packet_Data
);

   localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] SAMPLE_AT = CNT_W'(CLKS_PER_BIT / 2);
   localparam logic [CNT_W-1:0] WRAP_AT   = CNT_W'(CLKS_PER_BIT - 1);

   logic dpMeta_q, dpSync_q, dmMeta_q, dmSync_q;
   line_t lineNow, line_q, prevLine_q, prevLine_d;
   logic [CNT_W-1:0] cnt_q;
   logic jkEdge, samplePt, se0Now, jkSample, rawBit, decodeActive, stuffSlot;
   logic bitValid, stuffErr, byteDone, toErr, crcClear, crcShift;
   logic [7:0] newByte;
   logic [2:0] pidType;
   logic [15:0] crc;

   rx_state_t state_q, state_d;
   logic [2:0] ones_q, ones_d, bitCnt_q, bitCnt_d, pkt_q, pkt_d, pendPkt_q, pendPkt_d;
   logic [7:0] shift_q, shift_d, held0_q, held0_d, held1_q, held1_d, data_q, data_d;
   logic [1:0] heldCnt_q, heldCnt_d, eopCnt_q, eopCnt_d;
   logic errSe0_q, errSe0_d, err_q, err_d;
   logic ready_q, ready_d, flush_q, flush_d, store_q, store_d;

   assign lineNow  = line_t'({dpSync_q, dmSync_q});
   assign jkEdge   = (lineNow != line_q) && (lineNow inside {LINE_J, LINE_K})
                     && (line_q inside {LINE_J, LINE_K});
   assign samplePt = (cnt_q == SAMPLE_AT);
   assign se0Now   = samplePt && (line_q == LINE_SE0);
   assign jkSample = samplePt && (line_q inside {LINE_J, LINE_K});
   assign rawBit   = (line_q == prevLine_q);
   assign decodeActive = state_q inside {RX_SYNC, RX_PID, RX_TOKEN, RX_DATA};
   assign stuffSlot = (ones_q == 3'd6);
   assign bitValid = jkSample && decodeActive && !stuffSlot;
   assign stuffErr = jkSample && decodeActive && stuffSlot && rawBit;
   assign newByte  = {rawBit, shift_q[7:1]};
   assign byteDone = bitValid && (bitCnt_q == 3'd7);

   // Pad synchronizer plus the bit timer, which re-centres on every J<->K edge
   always_ff @(posedge clk) begin
      if (rst) begin
         dpMeta_q <= 1'b1;
         dpSync_q <= 1'b1;
         dmMeta_q <= 1'b0;
         dmSync_q <= 1'b0;
         line_q   <= LINE_J;
         cnt_q    <= '0;
      end else begin
         dpMeta_q <= Dplus_In;
         dpSync_q <= dpMeta_q;
         dmMeta_q <= Dminus_In;
         dmSync_q <= dmMeta_q;
         line_q   <= lineNow;
         cnt_q    <= (jkEdge || cnt_q == WRAP_AT) ? '0 : cnt_q + CNT_W'(1);
      end
   end

   usb_crc16 uCrc (
      .clk        (clk),
      .rst        (rst),
      .clear_i    (crcClear),
      .shift_en_i (crcShift),
      .bit_in_i   (rawBit),
      .crc_o      (crc)
   );

   always_comb begin
      state_d    = state_q;
      prevLine_d = prevLine_q;
      ones_d     = ones_q;
      bitCnt_d   = bitCnt_q;
      shift_d    = shift_q;
      held0_d    = held0_q;
      held1_d    = held1_q;
      heldCnt_d  = heldCnt_q;
      eopCnt_d   = eopCnt_q;
      errSe0_d   = errSe0_q;
      err_d      = err_q;
      pkt_d      = pkt_q;
      pendPkt_d  = pendPkt_q;
      data_d     = data_q;
      ready_d    = 1'b0;
      flush_d    = 1'b0;
      store_d    = 1'b0;
      toErr      = 1'b0;
      crcClear   = 1'b0;
      crcShift   = bitValid && (state_q == RX_DATA);
      pidType    = pidToPacket(newByte);

      if (jkSample) prevLine_d = line_q;
      if (jkSample && decodeActive) ones_d = (stuffSlot || !rawBit) ? 3'd0 : ones_q + 3'd1;
      if (bitValid) begin
         shift_d  = newByte;
         bitCnt_d = bitCnt_q + 3'd1;
      end

      case (state_q)
         RX_IDLE: begin
            prevLine_d = LINE_J;
            ones_d     = 3'd0;
            bitCnt_d   = 3'd0;
            if (line_q == LINE_K) begin
               state_d = RX_SYNC;
               err_d   = 1'b0;
            end
         end
         RX_SYNC: begin
            if (se0Now || stuffErr) toErr = 1'b1;
            else if (byteDone) begin
               if (newByte == SYNC_PATTERN) state_d = RX_PID;
               else toErr = 1'b1;
            end
         end
         RX_PID: begin
            crcClear = 1'b1;
            if (se0Now || stuffErr) toErr = 1'b1;
            else if (byteDone) begin
               if ((newByte[3:0] == ~newByte[7:4]) && (pidType != PKT_NONE)) begin
                  pendPkt_d = pidType;
                  heldCnt_d = 2'd0;
                  eopCnt_d  = 2'd0;
                  if (pidType inside {PKT_OUT, PKT_IN}) state_d = RX_TOKEN;
                  else if (pidType inside {PKT_DATA0, PKT_DATA1}) state_d = RX_DATA;
                  else state_d = RX_EOP;
               end else toErr = 1'b1;
            end
         end
         RX_TOKEN: begin
            if (se0Now || stuffErr) toErr = 1'b1;
            else if (byteDone) begin
               if (heldCnt_q == 2'd1) state_d = RX_EOP;
               else heldCnt_d = 2'd1;
            end
         end
         RX_DATA: begin
            // End of payload: the two held bytes are the CRC and the residual must match
            if (se0Now) begin
               if (bitCnt_q == 3'd0 && heldCnt_q == 2'd2 && crc == CRC16_RESIDUAL) begin
                  state_d  = RX_EOP;
                  eopCnt_d = 2'd1;
               end else toErr = 1'b1;
            end else if (stuffErr) toErr = 1'b1;
            else if (byteDone) begin
               if (heldCnt_q == 2'd2) begin
                  if (Buffer_Occupancy == 7'd64) toErr = 1'b1;
                  else begin
                     store_d = 1'b1;
                     data_d  = held0_q;
                     held0_d = held1_q;
                     held1_d = newByte;
                  end
               end else if (heldCnt_q == 2'd1) begin
                  held1_d   = newByte;
                  heldCnt_d = 2'd2;
               end else begin
                  held0_d   = newByte;
                  heldCnt_d = 2'd1;
               end
            end
         end
         RX_EOP: begin
            if (samplePt) begin
               if (line_q == LINE_SE0) begin
                  if (eopCnt_q == 2'd2) toErr = 1'b1;
                  else eopCnt_d = eopCnt_q + 2'd1;
               end else if (line_q == LINE_J && eopCnt_q == 2'd2) begin
                  pkt_d   = pendPkt_q;
                  ready_d = pendPkt_q inside {PKT_DATA0, PKT_DATA1};
                  state_d = RX_IDLE;
               end else toErr = 1'b1;
            end
         end
         RX_ERR: begin
            if (samplePt) begin
               if (line_q == LINE_SE0) errSe0_d = 1'b1;
               else if (line_q == LINE_J && errSe0_q) state_d = RX_IDLE;
            end
         end
         default: state_d = RX_IDLE;
      endcase

      if (toErr) begin
         state_d  = RX_ERR;
         err_d    = 1'b1;
         errSe0_d = se0Now;
         flush_d  = (state_q == RX_DATA);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= RX_IDLE;
         prevLine_q <= LINE_J;
         ones_q     <= '0;
         bitCnt_q   <= '0;
         shift_q    <= '0;
         held0_q    <= '0;
         held1_q    <= '0;
         heldCnt_q  <= '0;
         eopCnt_q   <= '0;
         errSe0_q   <= 1'b0;
         err_q      <= 1'b0;
         pkt_q      <= PKT_NONE;
         pendPkt_q  <= PKT_NONE;
         data_q     <= '0;
         ready_q    <= 1'b0;
         flush_q    <= 1'b0;
         store_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         prevLine_q <= prevLine_d;
         ones_q     <= ones_d;
         bitCnt_q   <= bitCnt_d;
         shift_q    <= shift_d;
         held0_q    <= held0_d;
         held1_q    <= held1_d;
         heldCnt_q  <= heldCnt_d;
         eopCnt_q   <= eopCnt_d;
         errSe0_q   <= errSe0_d;
         err_q      <= err_d;
         pkt_q      <= pkt_d;
         pendPkt_q  <= pendPkt_d;
         data_q     <= data_d;
         ready_q    <= ready_d;
         flush_q    <= flush_d;
         store_q    <= store_d;
      end
   end

   assign RX_Packet            = pkt_q;
   assign RX_Data_Ready        = ready_q;
   assign RX_Transfer_Active   = state_q inside {RX_SYNC, RX_PID, RX_TOKEN, RX_DATA, RX_EOP};
   assign RX_Error             = err_q;
   assign Flush                = flush_q;
   assign Store_RX_Packet_Data = store_q;
   assign RX_Packet_Data       = data_q;

endmodule
